// File: rtl/health_pkg.sv
// health_pkg: shared FSM encoding, counter width helper and stats width for the health monitor
package health_pkg;

    typedef enum logic [1:0] {HT_OK, HT_ERR, HT_FAIL} ht_state_e;

    localparam int STATS_W = 16;

    // Bits needed to hold values 0..n-1 (at least one bit)
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/health_channel.sv
// health_channel: repetition-count and adaptive-proportion test for one entropy channel
module health_channel
    import health_pkg::*;
#(
    parameter int WIN        = 1024,
    parameter int APT_CUTOFF = 589,
    parameter int RCT_CUTOFF = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic consume,
    input  logic win_end,
    input  logic bit_in,
    output logic err
);

    localparam int RW = cnt_w(RCT_CUTOFF + 1);
    localparam int OW = cnt_w(WIN + 1);

    logic          last_q, last_d;
    logic [RW-1:0] run_q, run_d;
    logic          rct_q, rct_d;
    logic [OW-1:0] ones_q, ones_d, ones_n;
    logic          apt_q, apt_d;

    assign err = rct_q | apt_q;

    // Run length saturates at the cutoff; ones count closes and evaluates on the window-ending sample
    always_comb begin
        ones_n = ones_q + OW'(bit_in);
        last_d = last_q;
        run_d  = run_q;
        rct_d  = rct_q;
        ones_d = ones_q;
        apt_d  = apt_q;
        if (clear) begin
            last_d = 1'b0;
            run_d  = '0;
            rct_d  = 1'b0;
            ones_d = '0;
            apt_d  = 1'b0;
        end else if (consume) begin
            last_d = bit_in;
            run_d  = (run_q != '0 && bit_in == last_q)
                   ? ((run_q == RW'(RCT_CUTOFF)) ? run_q : run_q + RW'(1))
                   : RW'(1);
            rct_d  = run_d >= RW'(RCT_CUTOFF);
            ones_d = win_end ? '0 : ones_n;
            if (win_end)
                apt_d = (ones_n > OW'(APT_CUTOFF)) || (ones_n < OW'(WIN - APT_CUTOFF));
        end
    end

    // Channel state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= 1'b0;
            run_q  <= '0;
            rct_q  <= 1'b0;
            ones_q <= '0;
            apt_q  <= 1'b0;
        end else begin
            last_q <= last_d;
            run_q  <= run_d;
            rct_q  <= rct_d;
            ones_q <= ones_d;
            apt_q  <= apt_d;
        end
    end

endmodule

// File: rtl/health_monitor.sv
// health_monitor: multi-channel TRNG online health test with error aggregation FSM.
// Define HEALTH_STATS_EN to add the saturating fail_count error-event counter.
module health_monitor
    import health_pkg::*;
#(
    parameter int NCH         = 4,
    parameter int WIN         = 1024,
    parameter int APT_CUTOFF  = 589,
    parameter int RCT_CUTOFF  = 32,
    parameter int FAIL_THRESH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               valid,
    input  logic [NCH-1:0]     samples,
    input  logic               clear,
    output logic               error,
    output logic               total_failure,
    output logic [NCH-1:0]     ch_error
`ifdef HEALTH_STATS_EN
    ,
    output logic [STATS_W-1:0] fail_count
`endif
);

    localparam int WW = cnt_w(WIN);
    localparam int CW = cnt_w(FAIL_THRESH + 1);

    logic          consume, win_end, any_err;
    logic [WW-1:0] win_q, win_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_n;
    ht_state_e     state_q, state_d;

    assign consume       = enable & valid;
    assign win_end       = win_q == WW'(WIN - 1);
    assign any_err       = |ch_error;
    assign error         = any_err & (state_q != HT_FAIL);
    assign total_failure = state_q == HT_FAIL;

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        health_channel #(
            .WIN        (WIN),
            .APT_CUTOFF (APT_CUTOFF),
            .RCT_CUTOFF (RCT_CUTOFF)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .clear   (clear),
            .consume (consume),
            .win_end (win_end),
            .bit_in  (samples[g]),
            .err     (ch_error[g])
        );
    end

    // Window position and consecutive-error FSM advance only on consumed samples; FAIL latches
    always_comb begin
        cnt_n   = (state_q == HT_ERR ? cnt_q : '0) + CW'(1);
        win_d   = win_q;
        cnt_d   = cnt_q;
        state_d = state_q;
        if (clear) begin
            win_d   = '0;
            cnt_d   = '0;
            state_d = HT_OK;
        end else if (consume) begin
            win_d = win_end ? '0 : win_q + WW'(1);
            if (state_q != HT_FAIL) begin
                cnt_d   = any_err ? cnt_n : '0;
                state_d = !any_err ? HT_OK : (cnt_n >= CW'(FAIL_THRESH)) ? HT_FAIL : HT_ERR;
            end
        end
    end

    // Window counter and FSM registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_q   <= '0;
            cnt_q   <= '0;
            state_q <= HT_OK;
        end else begin
            win_q   <= win_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

`ifdef HEALTH_STATS_EN
    logic               prev_q, prev_d;
    logic [STATS_W-1:0] fc_q, fc_d;

    assign fail_count = fc_q;

    // Count rising edges of the aggregated channel error, saturating at all-ones
    always_comb begin
        prev_d = clear ? 1'b0 : any_err;
        fc_d   = clear ? '0 : (any_err && !prev_q && fc_q != '1) ? fc_q + STATS_W'(1) : fc_q;
    end

    // Stats registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q <= 1'b0;
            fc_q   <= '0;
        end else begin
            prev_q <= prev_d;
            fc_q   <= fc_d;
        end
    end
`endif

endmodule
